// File: rtl/ieeedrv_ram_arbiter.sv
// ieeedrv_ram_arbiter
// Time-shares one single-port buffer RAM (8-bit data, 1-cycle read latency)
// between the DOS CPU (port A), the controller CPU (port B) and a host DMA
// port (port H). CPU strobes are captured into per-port pending registers and
// served with fixed priority A > B > host; the host only ever gets slots that
// neither CPU wants, so CPU latency stays bounded no matter what the host does.
//
// Ports:
//   clk_sys, reset        system clock, synchronous active-high reset
//   a_stb/a_addr/a_we/a_din, a_q   DOS CPU strobe-based access, read data held
//   b_stb/b_addr/b_we/b_din, b_q   controller CPU access, read data held
//   h_req/h_addr/h_we/h_din        host request (level, held until h_ack)
//   h_ack, h_q                     host completion pulse and read data
//   mem_addr/mem_we/mem_din, mem_q RAM interface
//   ovf                            sticky: strobe hit a still-pending request
module ieeedrv_ram_arbiter #(
  parameter int AW       = 12,
  parameter int H_STARVE = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          a_stb,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [7:0]    a_din,
  output logic [7:0]    a_q,
  input  logic          b_stb,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [7:0]    b_din,
  output logic [7:0]    b_q,
  input  logic          h_req,
  input  logic [AW-1:0] h_addr,
  input  logic          h_we,
  input  logic [7:0]    h_din,
  output logic          h_ack,
  output logic [7:0]    h_q,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_q,
  output logic          ovf
);

  localparam int            SW         = $clog2(H_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(H_STARVE);

  typedef enum logic [2:0] {IDLE, GRANT_A, GRANT_B, GRANT_H, RD_WAIT} state_e;
  typedef enum logic [1:0] {PORT_A, PORT_B, PORT_H} port_e;

  state_e        state_q, state_d;
  port_e         rdPort_q, rdPort_d;

  logic          aPend_q, aWe_q;
  logic [AW-1:0] aAddr_q;
  logic [7:0]    aDin_q;
  logic          bPend_q, bWe_q;
  logic [AW-1:0] bAddr_q;
  logic [7:0]    bDin_q;

  logic [7:0]    aQ_q, bQ_q, hQ_q;
  logic          hWrAck_q;
  logic          ovf_q;
  logic [AW-1:0] memAddrHold_q;
  logic [SW-1:0] starve_q;

  logic          aReq, bReq, hReq, hAck, hBusy;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [7:0]    memDin;
  logic          decide;

  // A pending request that is being granted this very cycle is no longer a
  // request; a fresh strobe always is, so back-to-back accesses need no gap.
  assign aReq = a_stb || (aPend_q && (state_q != GRANT_A));
  assign bReq = b_stb || (bPend_q && (state_q != GRANT_B));

  // The host still holds h_req during its grant and its ack cycle; masking
  // those cycles stops one request from being served twice.
  assign hAck  = hWrAck_q || ((state_q == RD_WAIT) && (rdPort_q == PORT_H));
  assign hBusy = (state_q == GRANT_H) || hAck;
  assign hReq  = h_req && !hBusy;

  assign a_q      = aQ_q;
  assign b_q      = bQ_q;
  assign h_ack    = hAck;
  assign h_q      = hAck ? mem_q : hQ_q;
  assign ovf      = ovf_q;
  assign mem_addr = memAddr;
  assign mem_din  = memDin;
  // Gating with reset keeps an interrupted write grant from reaching the RAM.
  assign mem_we   = memWe && !reset;

  // Strobe capture runs regardless of the FSM; a new strobe overrides the
  // clear that would otherwise happen when the old request is granted.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      aPend_q <= 1'b0;
      aWe_q   <= 1'b0;
      aAddr_q <= '0;
      aDin_q  <= 8'h00;
      bPend_q <= 1'b0;
      bWe_q   <= 1'b0;
      bAddr_q <= '0;
      bDin_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      if (a_stb) begin
        aPend_q <= 1'b1;
        aWe_q   <= a_we;
        aAddr_q <= a_addr;
        aDin_q  <= a_din;
      end else if (state_q == GRANT_A) begin
        aPend_q <= 1'b0;
      end
      if (b_stb) begin
        bPend_q <= 1'b1;
        bWe_q   <= b_we;
        bAddr_q <= b_addr;
        bDin_q  <= b_din;
      end else if (state_q == GRANT_B) begin
        bPend_q <= 1'b0;
      end
      if ((a_stb && aPend_q) || (b_stb && bPend_q)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Next-state and RAM drive. Reads detour through RD_WAIT to collect mem_q;
  // writes finish in their grant cycle and arbitrate again immediately.
  always_comb begin
    state_d  = state_q;
    rdPort_d = rdPort_q;
    memAddr  = memAddrHold_q;
    memWe    = 1'b0;
    memDin   = 8'h00;
    decide   = 1'b0;
    case (state_q)
      IDLE: decide = 1'b1;
      GRANT_A: begin
        memAddr = aAddr_q;
        memDin  = aDin_q;
        memWe   = aWe_q;
        if (aWe_q) begin
          decide = 1'b1;
        end else begin
          state_d  = RD_WAIT;
          rdPort_d = PORT_A;
        end
      end
      GRANT_B: begin
        memAddr = bAddr_q;
        memDin  = bDin_q;
        memWe   = bWe_q;
        if (bWe_q) begin
          decide = 1'b1;
        end else begin
          state_d  = RD_WAIT;
          rdPort_d = PORT_B;
        end
      end
      GRANT_H: begin
        memAddr = h_addr;
        memDin  = h_din;
        memWe   = h_we;
        if (h_we) begin
          decide = 1'b1;
        end else begin
          state_d  = RD_WAIT;
          rdPort_d = PORT_H;
        end
      end
      RD_WAIT: decide = 1'b1;
      default: state_d = IDLE;
    endcase
    if (decide) begin
      if (aReq) begin
        state_d = GRANT_A;
      end else if (bReq) begin
        state_d = GRANT_B;
      end else if (hReq) begin
        state_d = GRANT_H;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, read-data capture and the informational host starvation counter,
  // which saturates and never influences arbitration.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      rdPort_q      <= PORT_A;
      memAddrHold_q <= '0;
      hWrAck_q      <= 1'b0;
      aQ_q          <= 8'h00;
      bQ_q          <= 8'h00;
      hQ_q          <= 8'h00;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      rdPort_q      <= rdPort_d;
      memAddrHold_q <= memAddr;
      hWrAck_q      <= (state_q == GRANT_H) && h_we;
      if (state_q == RD_WAIT) begin
        case (rdPort_q)
          PORT_A:  aQ_q <= mem_q;
          PORT_B:  bQ_q <= mem_q;
          PORT_H:  hQ_q <= mem_q;
          default: ;
        endcase
      end
      if (!h_req || (state_d == GRANT_H)) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ieeedrv_ram_arbiter.sv
// tb_ieeedrv_ram_arbiter
// Drives the arbiter against a behavioural RAM and checks CPU/host data and
// latency bounds using a shadow memory of what each requester has written.
module tb_ieeedrv_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        a_stb, a_we, b_stb, b_we, h_req, h_we;
  logic [11:0] a_addr, b_addr, h_addr, mem_addr;
  logic [7:0]  a_din, b_din, h_din, a_q, b_q, h_q, mem_din, mem_q;
  logic        h_ack, mem_we, ovf;
  logic        ramClear;

  logic [7:0]  ram    [0:4095];
  logic [7:0]  expMem [0:4095];

  int checks = 0;
  int passes = 0;

  ieeedrv_ram_arbiter #(.AW(12), .H_STARVE(64)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_stb(a_stb), .a_addr(a_addr), .a_we(a_we), .a_din(a_din), .a_q(a_q),
    .b_stb(b_stb), .b_addr(b_addr), .b_we(b_we), .b_din(b_din), .b_q(b_q),
    .h_req(h_req), .h_addr(h_addr), .h_we(h_we), .h_din(h_din),
    .h_ack(h_ack), .h_q(h_q),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_q(mem_q),
    .ovf(ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk_sys) begin
    if (ramClear) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    mem_q <= ram[mem_addr];
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Called just after a negedge: strobes A and/or B for exactly one clock.
  task automatic applyStimulus(input bit aOn, input bit aW, input logic [11:0] aA,
                               input logic [7:0] aD, input bit bOn, input bit bW,
                               input logic [11:0] bA, input logic [7:0] bD);
    a_stb = aOn; a_we = aW; a_addr = aA; a_din = aD;
    b_stb = bOn; b_we = bW; b_addr = bA; b_din = bD;
    @(negedge clk_sys);
    a_stb = 1'b0; a_we = 1'b0;
    b_stb = 1'b0; b_we = 1'b0;
  endtask

  // Host handshake with a bounded wait; also checks that h_ack is one pulse.
  task automatic hostAccess(input bit we, input logic [11:0] addr, input logic [7:0] din,
                            output logic [7:0] q, output bit ok);
    h_req = 1'b1; h_we = we; h_addr = addr; h_din = din;
    ok = 1'b0; q = 8'h00;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk_sys);
      if (h_ack) begin
        ok = 1'b1;
        q  = h_q;
      end
    end
    h_req = 1'b0; h_we = 1'b0;
    @(negedge clk_sys);
    checkOutput("h_ack_pulse", 16'(h_ack), 16'h0);
  endtask

  task automatic doReset();
    reset = 1'b1; ramClear = 1'b1;
    a_stb = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_stb = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_din = '0;
    for (int i = 0; i < 4096; i++) expMem[i] = 8'h00;
    waitCycles(3);
    reset = 1'b0; ramClear = 1'b0;
    waitCycles(1);
  endtask

  initial begin
    logic [7:0] hq;
    bit         ok;

    doReset();
    $display("[TB] reset state");
    checkOutput("rst_a_q", 16'(a_q), 16'h0);
    checkOutput("rst_b_q", 16'(b_q), 16'h0);
    checkOutput("rst_h_ack", 16'(h_ack), 16'h0);
    checkOutput("rst_h_q", 16'(h_q), 16'h0);
    checkOutput("rst_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("rst_mem_we", 16'(mem_we), 16'h0);
    checkOutput("rst_mem_din", 16'(mem_din), 16'h0);
    checkOutput("rst_ovf", 16'(ovf), 16'h0);

    // Random CPU traffic in disjoint regions (A: 0x000-0x0FF, B: 0x100-0x1FF)
    // with a concurrent host in 0xF00-0xFFF; reads are checked at the latency
    // bound (A: 3 clk, B: 5 clk after the strobe edge).
    $display("[TB] random CPU and host traffic");
    fork
      begin
        int aCnt, bCnt, aDue, bDue;
        logic [7:0] aExp, bExp;
        aCnt = 1; bCnt = 3; aDue = -1; bDue = -1; aExp = 8'h00; bExp = 8'h00;
        for (int n = 0; n < 800; n++) begin
          if (n == aDue) checkOutput("rnd_a_q", 16'(a_q), 16'(aExp));
          if (n == bDue) checkOutput("rnd_b_q", 16'(b_q), 16'(bExp));
          a_stb = 1'b0; b_stb = 1'b0;
          aCnt = aCnt - 1;
          if (aCnt == 0) begin
            a_stb  = 1'b1;
            a_we   = 1'($urandom_range(0, 1));
            a_addr = 12'($urandom_range(0, 255));
            a_din  = 8'($urandom);
            if (a_we) expMem[a_addr] = a_din;
            else begin aDue = n + 4; aExp = expMem[a_addr]; end
            aCnt = int'($urandom_range(4, 7));
          end
          bCnt = bCnt - 1;
          if (bCnt == 0) begin
            b_stb  = 1'b1;
            b_we   = 1'($urandom_range(0, 1));
            b_addr = 12'(256 + $urandom_range(0, 255));
            b_din  = 8'($urandom);
            if (b_we) expMem[b_addr] = b_din;
            else begin bDue = n + 6; bExp = expMem[b_addr]; end
            bCnt = int'($urandom_range(6, 9));
          end
          @(negedge clk_sys);
        end
        a_stb = 1'b0; b_stb = 1'b0; a_we = 1'b0; b_we = 1'b0;
      end
      begin
        logic [11:0] ha;
        logic [7:0]  hd, rq;
        bit          hw, hok;
        for (int k = 0; k < 60; k++) begin
          hw = 1'($urandom_range(0, 1));
          ha = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'(12'hF00 + $urandom_range(0, 255));
          hd = 8'($urandom);
          hostAccess(hw, ha, hd, rq, hok);
          checkOutput("rnd_h_done", 16'(hok), 16'h1);
          if (hok) begin
            if (hw) expMem[ha] = hd;
            else checkOutput("rnd_h_q", 16'(rq), 16'(expMem[ha]));
          end
          waitCycles(int'($urandom_range(0, 3)));
        end
      end
    join
    waitCycles(8);
    checkOutput("rnd_ovf", 16'(ovf), 16'h0);

    $display("[TB] A write then read");
    applyStimulus(1'b1, 1'b1, 12'h123, 8'h5A, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(3);
    applyStimulus(1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(3);
    checkOutput("t1_a_q", 16'(a_q), 16'h5A);

    $display("[TB] simultaneous A write and B read, same address");
    applyStimulus(1'b1, 1'b1, 12'h010, 8'h11, 1'b1, 1'b0, 12'h010, 8'h00);
    waitCycles(5);
    checkOutput("t2_b_q", 16'(b_q), 16'h11);
    checkOutput("t2_ovf", 16'(ovf), 16'h0);

    $display("[TB] host fill and DOS readback");
    for (int i = 0; i < 4096; i++) begin
      hostAccess(1'b1, 12'(i), 8'(i) ^ 8'hA5, hq, ok);
      checkOutput("t6_h_done", 16'(ok), 16'h1);
    end
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(1'b1, 1'b0, 12'(i), 8'h00, 1'b0, 1'b0, 12'h0, 8'h0);
      waitCycles(3);
      checkOutput("t6_a_q", 16'(a_q), 16'(8'(i) ^ 8'hA5));
    end
    checkOutput("t6_ovf", 16'(ovf), 16'h0);

    $display("[TB] overwrite of a pending A request");
    applyStimulus(1'b1, 1'b1, 12'h300, 8'h33, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 12'h0, 8'h00, 1'b1, 1'b0, 12'h200, 8'h00);
    applyStimulus(1'b1, 1'b1, 12'h300, 8'h77, 1'b0, 1'b0, 12'h0, 8'h0);
    applyStimulus(1'b1, 1'b1, 12'h301, 8'h88, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(4);
    checkOutput("t4_ovf", 16'(ovf), 16'h1);
    checkOutput("t4_b_q", 16'(b_q), 16'hA5);
    applyStimulus(1'b1, 1'b0, 12'h300, 8'h00, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(3);
    checkOutput("t4_first_dropped", 16'(a_q), 16'h33);
    applyStimulus(1'b1, 1'b0, 12'h301, 8'h00, 1'b0, 1'b0, 12'h0, 8'h0);
    waitCycles(3);
    checkOutput("t4_second_done", 16'(a_q), 16'h88);

    $display("[TB] reset during a B write grant");
    applyStimulus(1'b0, 1'b0, 12'h0, 8'h00, 1'b1, 1'b1, 12'h400, 8'h44);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("t5_mem_we", 16'(mem_we), 16'h0);
    checkOutput("t5_h_ack", 16'(h_ack), 16'h0);
    checkOutput("t5_a_q", 16'(a_q), 16'h0);
    checkOutput("t5_b_q", 16'(b_q), 16'h0);
    checkOutput("t5_h_q", 16'(h_q), 16'h0);
    checkOutput("t5_ovf", 16'(ovf), 16'h0);
    checkOutput("t5_mem_addr", 16'(mem_addr), 16'h0);
    checkOutput("t5_mem_din", 16'(mem_din), 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitCycles(1);
      checkOutput("t5_idle_we", 16'(mem_we), 16'h0);
      checkOutput("t5_idle_ack", 16'(h_ack), 16'h0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
